fetch_unit: RTL and testbench

//  Instruction fetch front-end for the pipelined RV32 core; replaces the direct IMEM_addr_o/IMEM_data_i hookup in the core top.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and fetch FSM state type
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    RESET_VECTOR = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0013;

  // S_BOOT is a single idle cycle after reset release; S_FETCH then runs forever.
  typedef enum logic {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered synchronous FIFO with flush, used as the prefetch buffer
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush discards everything including this cycle's push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pipelined instruction fetch front-end with prefetch FIFO and redirect flush
module fetch_unit #(
  parameter int                        XLEN       = riscv_pkg::XLEN,
  parameter int                        FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0]           RESET_PC   = riscv_pkg::RESET_VECTOR
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              IMEM_req_o,
  output logic [XLEN-1:0]   IMEM_addr_o,
  input  logic              IMEM_gnt_i,
  input  logic              IMEM_rvalid_i,
  input  logic [31:0]       IMEM_data_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [XLEN-1:0]   instr_pc_o,
  input  logic              instr_ready_i
);

  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = INSTR_W + XLEN;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_e     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  redirect_pc_aligned;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    outstanding_nxt;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      inflight;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_head;
  logic             issue;
  logic             rsp_ok;
  logic             rsp_keep;
  logic             push;
  logic             pop;

  assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);

  // Buffered plus in-flight words never exceed the FIFO size, so the FIFO cannot overflow.
  assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign IMEM_req_o = (state == S_FETCH) && (inflight < DEPTH_C);
  assign IMEM_addr_o = fetch_pc;
  assign issue      = IMEM_req_o && IMEM_gnt_i;

  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok   = IMEM_rvalid_i && (outstanding != '0);
  assign rsp_keep = rsp_ok && (discard == '0);
  assign push     = rsp_keep && !redirect_i;
  assign pop      = instr_valid_o && instr_ready_i;

  // Outstanding count after this cycle's grant and response.
  always_comb begin
    outstanding_nxt = outstanding + CW'(issue) - CW'(rsp_ok);
  end

  // Boot FSM: one idle cycle after reset release, then fetch permanently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_BOOT;
    end else if (state == S_BOOT) begin
      state <= S_FETCH;
    end
  end

  // Next fetch address: redirect overrides, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_aligned;
    end else if (issue) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // In-flight tracking; on redirect every request still in flight becomes stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        discard <= outstanding_nxt;
      end else if (rsp_ok && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

  // PC of the next live response; responses return in issue order from a contiguous stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_pc <= RESET_PC;
    end else if (redirect_i) begin
      resp_pc <= redirect_pc_aligned;
    end else if (rsp_keep) begin
      resp_pc <= resp_pc + XLEN'(4);
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_i),
    .push      (push),
    .push_data ({IMEM_data_i, resp_pc}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : fifo_head[FW-1:XLEN];
  assign instr_pc_o    = fifo_empty ? '0 : fifo_head[XLEN-1:0];

  // Protocol checks: no response without a request, no push into a full buffer.
  assert property (@(posedge clk) disable iff (!reset_n) !(IMEM_rvalid_i && (outstanding == '0)));
  assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue-based model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IMEM_req_o;
  logic [31:0] IMEM_addr_o;
  logic        IMEM_gnt_i;
  logic        IMEM_rvalid_i;
  logic [31:0] IMEM_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN       (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .IMEM_req_o    (IMEM_req_o),
    .IMEM_addr_o   (IMEM_addr_o),
    .IMEM_gnt_i    (IMEM_gnt_i),
    .IMEM_rvalid_i (IMEM_rvalid_i),
    .IMEM_data_i   (IMEM_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  typedef struct { logic [31:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int cyc; } mreq_t;

  req_t  issued_q[$];
  ent_t  fifo_q[$];
  mreq_t mem_q[$];
  bit          m_fetching;
  logic [31:0] m_pc;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic        s_req, s_valid, s_hs;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    issued_q.delete();
    fifo_q.delete();
    mem_q.delete();
    m_fetching = 1'b0;
    m_pc       = 32'h0;
  endtask

  // Called at a falling edge: compare, drive this cycle's inputs, advance the model, move to next falling edge.
  task automatic step(input bit g, input bit rv, input bit rdy, input bit rd, input logic [31:0] rpc);
    bit   e_req, e_valid, rv_now;
    req_t r;
    e_req   = m_fetching && ((fifo_q.size() + issued_q.size()) < 4);
    e_valid = (fifo_q.size() != 0);
    s_req   = IMEM_req_o;
    s_addr  = IMEM_addr_o;
    s_valid = instr_valid_o;
    s_instr = instr_o;
    s_pc    = instr_pc_o;
    check("req", {31'd0, IMEM_req_o}, {31'd0, e_req});
    check("addr", IMEM_addr_o, m_pc);
    check("valid", {31'd0, instr_valid_o}, {31'd0, e_valid});
    if (e_valid) begin
      check("instr", instr_o, fifo_q[0].instr);
      check("instr_pc", instr_pc_o, fifo_q[0].pc);
    end

    rv_now = rv && (mem_q.size() > 0) && (mem_q[0].cyc < cyc);
    IMEM_gnt_i    = g;
    IMEM_rvalid_i = rv_now;
    IMEM_data_i   = rv_now ? mem_word(mem_q[0].addr) : $urandom();
    redirect_i    = rd;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    s_hs = IMEM_req_o && g;
    if (rv_now) void'(mem_q.pop_front());
    if (s_hs) mem_q.push_back(mreq_t'{IMEM_addr_o, cyc});

    if (e_valid && rdy) void'(fifo_q.pop_front());
    if (rv_now && (issued_q.size() > 0)) begin
      r = issued_q.pop_front();
      if (!r.stale && !rd) fifo_q.push_back(ent_t'{mem_word(r.pc), r.pc});
    end
    if (e_req && g) begin
      issued_q.push_back(req_t'{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (rd) begin
      foreach (issued_q[i]) issued_q[i].stale = 1'b1;
      fifo_q.delete();
      m_pc = rpc & ~32'h3;
    end
    m_fetching = 1'b1;

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_req", {31'd0, IMEM_req_o}, 32'd0);
    check("rst_addr", IMEM_addr_o, 32'h0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    IMEM_gnt_i    = 1'b0;
    IMEM_rvalid_i = 1'b0;
    IMEM_data_i   = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        seen = 1'b1;
        check(name, s_pc, exp_pc);
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int          grants;
    logic [31:0] prev;
    reset_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Steady streaming: always granted, one-cycle response, decode always ready.
    step(1, 1, 1, 0, 0);
    check("t1_boot_req", {31'd0, s_req}, 32'd0);
    step(1, 1, 1, 0, 0);
    check("t1_req", {31'd0, s_req}, 32'd1);
    check("t1_addr0", s_addr, 32'h0);
    step(1, 1, 1, 0, 0);
    check("t1_addr1", s_addr, 32'h4);
    step(1, 1, 1, 0, 0);
    check("t1_first_valid", {31'd0, s_valid}, 32'd1);
    check("t1_first_pc", s_pc, 32'h0);
    check("t1_first_instr", s_instr, 32'h1357_9BDF);
    step(1, 1, 1, 0, 0);
    check("t1_second_pc", s_pc, 32'h4);
    for (int i = 0; i < 20; i++) begin
      prev = s_pc;
      step(1, 1, 1, 0, 0);
      check("t1_steady", s_pc, prev + 32'd4);
    end

    // Decode stalled: exactly four grants, then request drops and head stays at PC 0.
    do_reset();
    grants = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 0, 0, 0);
      grants += int'(s_hs);
    end
    check("t2_grants", grants, 32'd4);
    check("t2_req_low", {31'd0, s_req}, 32'd0);
    check("t2_head_pc", s_pc, 32'h0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);

    // Random grant/response/ready stalls, no redirect.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, 0, 0);

    // Random traffic with random redirects (includes PC wrap near the top of the space).
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 5, $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom());

    // Redirect with three requests in flight.
    do_reset();
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 32'h103);
    check("t4_pre_addr", s_addr, 32'hC);
    step(0, 1, 1, 0, 0);
    check("t4_new_addr", s_addr, 32'h100);
    wait_first_valid("t4_first_pc", 32'h100);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);

    // Redirect coinciding with grant and response; then back-to-back redirects.
    do_reset();
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 32'h200);
    check("t5_same_cycle_req", {31'd0, s_req}, 32'd1);
    wait_first_valid("t5_first_pc", 32'h200);
    step(1, 1, 1, 1, 32'h300);
    step(1, 1, 1, 1, 32'h400);
    step(1, 1, 1, 0, 0);
    check("t5_last_wins_addr", s_addr, 32'h400);
    wait_first_valid("t5_b2b_pc", 32'h400);

    // Mid-stream reset with requests in flight, then restart from the reset PC.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 50, 0, 0);
    do_reset();
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check("t6_restart_addr", s_addr, 32'h0);
    wait_first_valid("t6_restart_pc", 32'h0);
    for (int i = 0; i < 50; i++) step(1, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
